alarm_ctrl: RTL
===============

# alarm_ctrl

Alarm stage downstream of the timekeeping counter in the digital-clock top: it consumes the running hour/minute/second, holds a user-set alarm time, and drives a buzzer tone when the time matches. It provides setting, ring-timeout, stop and snooze behaviour. Its `speak` output is OR-combined with the hourly-chime tone in the top level.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TONE_HZ`, 1000, buzzer square-wave frequency; half period HALF = CLK_HZ/(2*TONE_HZ) cycles.
- `RING_SEC`, 30, ring duration before auto-stop, in clock-seconds.
- `SNOOZE_MIN`, 5, snooze delay in minutes (1..59).
- `DEBOUNCE_CYC`, 2_000_000, stable cycles required to accept a button edge.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alarm_on`  in  1  level switch; 0 disarms the alarm.
- `set_mode`  in  1  level switch; 1 enables alarm-time editing.
- `btn_h`, `btn_m`  in  1  raw buttons; increment alarm hour / minute.
- `btn_stop`, `btn_snooze`  in  1  raw buttons.
- `hour`, `minute`, `second`  in  6  current time, binary, from the clock counter.
- `al_hour`, `al_minute`  out  6  stored alarm time; reset 7 / 0.
- `state`  out  2  FSM state; reset DISARMED.
- `ringing`  out  1  high in RINGING; reset 0.
- `speak`  out  1  buzzer drive; reset 0.

## Operation
- All four buttons pass through debounce: 2-FF sync, accept the new level after DEBOUNCE_CYC stable cycles, emit a one-cycle pulse on the accepted rising edge.
- Editing: with `set_mode`=1 and state≠RINGING, an h pulse sets al_hour=(al_hour+1) mod 24 and an m pulse sets al_minute=(al_minute+1) mod 60. Pulses are ignored otherwise. There is no carry from minute to hour.
- match = (hour==al_hour && minute==al_minute && second==0). The trigger is the rising edge of registered match (match true, previous-cycle match false).
- FSM states: DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3.
  - Any state: `alarm_on`=0 → DISARMED next cycle.
  - DISARMED: `alarm_on`=1 → ARMED.
  - ARMED: trigger → RINGING; load ring_cnt=RING_SEC.
  - RINGING: on each change of `second` (second≠prev_second), decrement ring_cnt. At ring_cnt reaching 0 → ARMED.
  - RINGING: stop pulse → ARMED.
  - RINGING: snooze pulse → SNOOZE; latch target = time + SNOOZE_MIN minutes (minute wrap at 60 carries into hour; hour wraps 23→0).
  - RINGING: stop and snooze in the same cycle → stop wins.
  - SNOOZE: target match edge (target h/m, second==0) → RINGING with ring_cnt reloaded. Stop pulse → ARMED.
- Editing the alarm time during SNOOZE does not alter the latched snooze target.
- Tone: in RINGING, a counter toggles tone every HALF cycles. speak = tone && (second[0]==0), giving 1 s on / 1 s off beeping. Outside RINGING, the tone counter and tone are held at 0 and speak=0.

## Timing
- Time inputs are registered once. `ringing` rises 2 cycles after the cycle in which matching time inputs first appear.
- Button pulse appears DEBOUNCE_CYC+3 cycles after a clean raw edge. The alarm time register updates on the cycle after the pulse.
- speak first goes high HALF cycles after RINGING entry, provided second is even.
- FSM exit from RINGING on stop/snooze occurs 1 cycle after the pulse.
- Reset mid-ring: all outputs return to reset values immediately (asynchronous); the stored alarm time is lost.
- A clock-set jump onto an exact match with second==0 does trigger; holding at match does not retrigger.

## Structure
- Shared include `alarm_defs.vh`: state encodings, HOURS=24, MINUTES=60.
- Sub-module `btn_pulse` (sync + debounce + edge pulse), instantiated 4×; parameter DEBOUNCE_CYC.
- FSM, counters and tone generator live in `alarm_ctrl`.

## Test plan
Bench parameters: CLK_HZ=1000, TONE_HZ=100 (HALF=5), DEBOUNCE_CYC=4, RING_SEC=3, SNOOZE_MIN=5.
- Reset, then `set_mode`=1 with 8 h presses and 30 m presses → al_hour=15, al_minute=30. Further presses with `set_mode`=0 → unchanged.
- al=07:00, `alarm_on`=1, time stepped 06:59:59→07:00:00 → `ringing`=1 two cycles later. speak toggles with period 10 cycles while second is even, and is 0 while second is odd.
- While ringing, step seconds 00→01→02→03 → state ARMED after the third second change; speak=0.
- al=23:58, ring, then snooze → SNOOZE. Time 00:03:00 → RINGING. Stop and snooze pressed together → ARMED.
- `alarm_on`=0 mid-ring → DISARMED next cycle, speak=0. Async `rst` mid-ring → al=07:00, state 0, outputs 0 without waiting for a clock edge.
- Button glitch shorter than 4 cycles → no increment.

Source files
------------

// File: rtl/alarm_ctrl_pkg.sv
// Shared types for the alarm stage: FSM encoding, time ranges, hour/minute arithmetic.
// Pure declarations, no logic, so there is no latency.
// Not applicable: this package has no handshake.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

    localparam int HOURS   = 24;
    localparam int MINUTES = 60;

    typedef struct packed {
        logic [5:0] h;
        logic [5:0] m;
    } hm_t;

    // Add d minutes (d < 60) to h:m, carrying minute overflow into the hour and wrapping 23->0.
    function automatic hm_t add_minutes(input logic [5:0] h, input logic [5:0] m,
                                        input logic [5:0] d);
        logic [6:0] sum;
        hm_t        r;
        sum = {1'b0, m} + {1'b0, d};
        if (sum >= 7'(MINUTES)) begin
            r.m = 6'(sum - 7'(MINUTES));
            r.h = (h == 6'(HOURS - 1)) ? 6'd0 : h + 6'd1;
        end else begin
            r.m = sum[5:0];
            r.h = h;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Bundles the alarm stage's switches, buttons, time inputs and status outputs.
// Wires only; no latency.
// No backpressure: every signal is a level or a raw button.
interface alarm_ctrl_if;
    import alarm_ctrl_pkg::*;

    logic       alarm_on;
    logic       set_mode;
    logic       btn_h;
    logic       btn_m;
    logic       btn_stop;
    logic       btn_snooze;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [5:0] al_hour;
    logic [5:0] al_minute;
    state_t     state;
    logic       ringing;
    logic       speak;

    modport master (
        output alarm_on, set_mode, btn_h, btn_m, btn_stop, btn_snooze,
        output hour, minute, second,
        input  al_hour, al_minute, state, ringing, speak
    );

    modport slave (
        input  alarm_on, set_mode, btn_h, btn_m, btn_stop, btn_snooze,
        input  hour, minute, second,
        output al_hour, al_minute, state, ringing, speak
    );
endinterface

// File: rtl/alarm_ctrl_btn_pulse.sv
// Synchronises and debounces one raw button and emits a one-cycle pulse on an accepted press.
// Pulse appears DEBOUNCE_CYC+3 cycles after a clean raw rising edge.
// No backpressure; glitches that do not stay stable long enough are dropped.
module alarm_ctrl_btn_pulse #(
    parameter int DEBOUNCE_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync1 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC)) begin
                    level <= sync1;
                    cnt   <= '0;
                    pulse <= sync1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm stage: holds the alarm time, rings on a time match, handles stop, snooze and timeout.
// ringing rises 2 cycles after matching time inputs; stop/snooze act 1 cycle after the button pulse.
// No backpressure: time is sampled every cycle and buttons are edge pulses.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TONE_HZ      = 1000,
    parameter int RING_SEC     = 30,
    parameter int SNOOZE_MIN   = 5,
    parameter int DEBOUNCE_CYC = 2_000_000
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);
    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int TW   = $clog2(HALF + 1);
    localparam int RW   = $clog2(RING_SEC + 1);

    logic          h_pls, m_pls, stop_pls, snz_pls;
    logic [5:0]    hour_r, minute_r, second_r, prev_second_r;
    logic [5:0]    al_hour, al_minute;
    logic          match, match_q, tmatch, tmatch_q;
    logic          trigger, ttrigger, sec_chg, ring_done, edit_ok;
    hm_t           tgt, snz_hm;
    state_t        state, next_state;
    logic [RW-1:0] ring_cnt;
    logic [TW-1:0] tone_cnt;
    logic          tone;

    alarm_ctrl_btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_h
        (.clk(clk), .rst(rst), .raw(bus.btn_h), .pulse(h_pls));
    alarm_ctrl_btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_m
        (.clk(clk), .rst(rst), .raw(bus.btn_m), .pulse(m_pls));
    alarm_ctrl_btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_stop
        (.clk(clk), .rst(rst), .raw(bus.btn_stop), .pulse(stop_pls));
    alarm_ctrl_btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_snooze
        (.clk(clk), .rst(rst), .raw(bus.btn_snooze), .pulse(snz_pls));

    assign match     = (hour_r == al_hour) && (minute_r == al_minute) && (second_r == 6'd0);
    assign tmatch    = (hour_r == tgt.h) && (minute_r == tgt.m) && (second_r == 6'd0);
    assign trigger   = match && !match_q;
    assign ttrigger  = tmatch && !tmatch_q;
    assign sec_chg   = (second_r != prev_second_r);
    assign ring_done = sec_chg && (ring_cnt <= RW'(1));
    assign edit_ok   = bus.set_mode && (state != RINGING);
    assign snz_hm    = add_minutes(hour_r, minute_r, 6'(SNOOZE_MIN));

    // Register the time inputs once and keep previous-cycle match flags for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_r        <= '0;
            minute_r      <= '0;
            second_r      <= '0;
            prev_second_r <= '0;
            match_q       <= 1'b0;
            tmatch_q      <= 1'b0;
        end else begin
            hour_r        <= bus.hour;
            minute_r      <= bus.minute;
            second_r      <= bus.second;
            prev_second_r <= second_r;
            match_q       <= match;
            tmatch_q      <= tmatch;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DISARMED;
        else     state <= next_state;
    end

    // FSM next state; disarm overrides everything, stop beats snooze.
    always_comb begin
        next_state = state;
        if (!bus.alarm_on) begin
            next_state = DISARMED;
        end else begin
            case (state)
                DISARMED: next_state = ARMED;
                ARMED:    if (trigger) next_state = RINGING;
                RINGING: begin
                    if (stop_pls)       next_state = ARMED;
                    else if (snz_pls)   next_state = SNOOZE;
                    else if (ring_done) next_state = ARMED;
                end
                SNOOZE: begin
                    if (stop_pls)      next_state = ARMED;
                    else if (ttrigger) next_state = RINGING;
                end
                default: next_state = DISARMED;
            endcase
        end
    end

    // Ring seconds left, reloaded on every entry to RINGING; snooze target latched on snooze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_cnt <= '0;
            tgt      <= '0;
        end else begin
            if (next_state == RINGING && state != RINGING)
                ring_cnt <= RW'(RING_SEC);
            else if (state == RINGING && sec_chg)
                ring_cnt <= ring_cnt - RW'(1);
            if (state == RINGING && next_state == SNOOZE)
                tgt <= snz_hm;
        end
    end

    // Alarm time editing; hour and minute wrap independently with no carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_hour   <= 6'd7;
            al_minute <= 6'd0;
        end else if (edit_ok) begin
            if (h_pls) al_hour   <= (al_hour == 6'(HOURS - 1)) ? 6'd0 : al_hour + 6'd1;
            if (m_pls) al_minute <= (al_minute == 6'(MINUTES - 1)) ? 6'd0 : al_minute + 6'd1;
        end
    end

    // Square-wave tone that only runs while ringing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (state != RINGING) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == TW'(HALF - 1)) begin
            tone_cnt <= '0;
            tone     <= ~tone;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end

    // Outputs: ringing flag and buzzer gated to even seconds for 1 s on / 1 s off beeping.
    always_comb begin
        bus.ringing = (state == RINGING);
        bus.speak   = (state == RINGING) && tone && !second_r[0];
    end

    assign bus.state     = state;
    assign bus.al_hour   = al_hour;
    assign bus.al_minute = al_minute;
endmodule
